// File: rtl/mem_stage_if.sv
// Pipeline MEM-stage bundle: EX/MEM inputs, fetch redirect, stall and MEM/WB outputs.
interface mem_stage_if;
  logic [1:0]  WB_in;
  logic [4:0]  M_in;
  logic [4:0]  RdAddr_in;
  logic [31:0] Result_in;
  logic [31:0] RtData_in;
  logic [31:0] b_tgt_in;
  logic        zero_in;
  logic [31:0] pc_incr_in;
  logic [25:0] jumpoffset_in;
  logic        PCSrc;
  logic [31:0] next_pc;
  logic        stall;
  logic [1:0]  WB_out;
  logic [4:0]  RdAddr_out;
  logic [31:0] Result_out;
  logic [31:0] ReadData_out;

  modport master (
    output WB_in, M_in, RdAddr_in, Result_in, RtData_in, b_tgt_in, zero_in,
           pc_incr_in, jumpoffset_in,
    input  PCSrc, next_pc, stall, WB_out, RdAddr_out, Result_out, ReadData_out
  );

  modport slave (
    input  WB_in, M_in, RdAddr_in, Result_in, RtData_in, b_tgt_in, zero_in,
           pc_incr_in, jumpoffset_in,
    output PCSrc, next_pc, stall, WB_out, RdAddr_out, Result_out, ReadData_out
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data memory with configurable wait states,
// branch/jump redirect and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stall_raw;
  logic        complete;
  logic        mem_op;
  logic        is_wr;
  logic        is_rd;
  logic        wr_en;
  logic [AW-1:0] idx;
  logic [31:0] rdata;

  logic [31:0] mem_q [MEM_DEPTH];
  logic [1:0]  wb_q;
  logic [4:0]  rd_q;
  logic [31:0] res_q;
  logic [31:0] rdat_q;

  assign mem_op = bus.M_in[0] | bus.M_in[1];
  assign is_wr  = bus.M_in[1];
  assign is_rd  = bus.M_in[0] & ~bus.M_in[1];
  assign idx    = AW'({24'd0, bus.Result_in[9:2]} % MEM_DEPTH);
  assign rdata  = is_rd ? mem_q[idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter reaches 0 as the FSM enters DONE, so the IDLE cycle plus the
  // WAIT cycles give exactly WAIT_CYCLES stalled cycles per op.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && (WAIT_CYCLES != 0)) begin
          stall_raw = 1'b1;
          cnt_d     = 3'(WAIT_CYCLES - 1);
          state_d   = (WAIT_CYCLES == 1) ? DONE : WAIT;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en = complete & is_wr & rst_n;

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= bus.RtData_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q   <= '0;
      rd_q   <= '0;
      res_q  <= '0;
      rdat_q <= '0;
    end else if (stall_raw) begin
      wb_q <= '0;
    end else begin
      wb_q   <= bus.WB_in;
      rd_q   <= bus.RdAddr_in;
      res_q  <= bus.Result_in;
      rdat_q <= rdata;
    end
  end

  assign bus.stall        = stall_raw & rst_n;
  assign bus.PCSrc        = (bus.M_in[3] | (bus.M_in[2] & bus.zero_in)) & ~bus.stall;
  assign bus.next_pc      = bus.M_in[3] ? {bus.pc_incr_in[31:28], bus.jumpoffset_in, 2'b00}
                                        : bus.b_tgt_in;
  assign bus.WB_out       = wb_q;
  assign bus.RdAddr_out   = rd_q;
  assign bus.Result_out   = res_q;
  assign bus.ReadData_out = rdat_q;

  logic unused_ok;
  assign unused_ok = ^{bus.M_in[4], bus.Result_in[31:10], bus.Result_in[1:0],
                       bus.pc_incr_in[27:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two instances (2 and 0 wait states) share one stimulus
// stream and are compared every cycle against a stall-count reference model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_if if2();
  mem_stage_if if0();

  mem_stage #(.WAIT_CYCLES(2), .MEM_DEPTH(256)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mem_stage #(.WAIT_CYCLES(0), .MEM_DEPTH(256)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  logic [1:0]  wb_v;
  logic [4:0]  m_v;
  logic [4:0]  rd_v;
  logic [31:0] res_v, rt_v, bt_v, pci_v;
  logic        z_v;
  logic [25:0] jo_v;

  assign if2.WB_in = wb_v;        assign if0.WB_in = wb_v;
  assign if2.M_in = m_v;          assign if0.M_in = m_v;
  assign if2.RdAddr_in = rd_v;    assign if0.RdAddr_in = rd_v;
  assign if2.Result_in = res_v;   assign if0.Result_in = res_v;
  assign if2.RtData_in = rt_v;    assign if0.RtData_in = rt_v;
  assign if2.b_tgt_in = bt_v;     assign if0.b_tgt_in = bt_v;
  assign if2.zero_in = z_v;       assign if0.zero_in = z_v;
  assign if2.pc_incr_in = pci_v;  assign if0.pc_incr_in = pci_v;
  assign if2.jumpoffset_in = jo_v; assign if0.jumpoffset_in = jo_v;

  logic        st_o [2];
  logic        pcs_o [2];
  logic [31:0] npc_o [2];
  logic [1:0]  wb_o [2];
  logic [4:0]  rd_o [2];
  logic [31:0] res_o [2];
  logic [31:0] rdat_o [2];

  assign st_o[0] = if2.stall;          assign st_o[1] = if0.stall;
  assign pcs_o[0] = if2.PCSrc;         assign pcs_o[1] = if0.PCSrc;
  assign npc_o[0] = if2.next_pc;       assign npc_o[1] = if0.next_pc;
  assign wb_o[0] = if2.WB_out;         assign wb_o[1] = if0.WB_out;
  assign rd_o[0] = if2.RdAddr_out;     assign rd_o[1] = if0.RdAddr_out;
  assign res_o[0] = if2.Result_out;    assign res_o[1] = if0.Result_out;
  assign rdat_o[0] = if2.ReadData_out; assign rdat_o[1] = if0.ReadData_out;

  // Reference model: per instance, stall cycles already spent on the current op.
  logic [31:0] mm [2][256];
  int unsigned k [2];
  logic [1:0]  e_wb [2];
  logic [4:0]  e_rd [2];
  logic [31:0] e_res [2];
  logic [31:0] e_rdat [2];

  int n_cmp = 0;
  int n_err = 0;
  int stall0_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned wt(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_stall(input int d);
    return rst_n && (m_v[0] || m_v[1]) && (wt(d) > 0) && (k[d] < wt(d));
  endfunction

  task automatic model_edge(input int d, input bit s);
    int idx;
    if (s) begin
      k[d]++;
      e_wb[d] = 2'b00;
    end else begin
      k[d]     = 0;
      idx      = int'(res_v[9:2]) % 256;
      e_wb[d]  = wb_v;
      e_rd[d]  = rd_v;
      e_res[d] = res_v;
      e_rdat[d] = (m_v[0] && !m_v[1]) ? mm[d][idx] : 32'd0;
      if (m_v[1]) mm[d][idx] = rt_v;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      k[d] = 0; e_wb[d] = '0; e_rd[d] = '0; e_res[d] = '0; e_rdat[d] = '0;
    end
  endtask

  task automatic check_regs(input int d);
    check($sformatf("wb_out[%0d]", d), 32'(wb_o[d]), 32'(e_wb[d]));
    check($sformatf("rd_out[%0d]", d), 32'(rd_o[d]), 32'(e_rd[d]));
    check($sformatf("result_out[%0d]", d), res_o[d], e_res[d]);
    check($sformatf("readdata_out[%0d]", d), rdat_o[d], e_rdat[d]);
  endtask

  task automatic step(output bit stalled);
    bit s [2];
    #1;
    for (int d = 0; d < 2; d++) begin
      s[d] = exp_stall(d);
      check($sformatf("stall[%0d]", d), 32'(st_o[d]), 32'(s[d]));
      check($sformatf("pcsrc[%0d]", d), 32'(pcs_o[d]),
            32'((m_v[3] | (m_v[2] & z_v)) & ~s[d]));
      check($sformatf("next_pc[%0d]", d), npc_o[d],
            m_v[3] ? {pci_v[31:28], jo_v, 2'b00} : bt_v);
    end
    if (st_o[1]) stall0_seen++;
    stalled = s[0];
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 2; d++) model_edge(d, s[d]);
    #1;
    for (int d = 0; d < 2; d++) check_regs(d);
  endtask

  task automatic set_in(input logic [1:0] wb, input logic [4:0] m, input logic [4:0] rd,
                        input logic [31:0] res, input logic [31:0] rt, input logic [31:0] bt,
                        input logic z, input logic [31:0] pci, input logic [25:0] jo);
    wb_v = wb; m_v = m; rd_v = rd; res_v = res; rt_v = rt;
    bt_v = bt; z_v = z; pci_v = pci; jo_v = jo;
  endtask

  task automatic run_op(output int ns);
    bit st;
    int guard;
    ns = 0;
    guard = 0;
    do begin
      step(st);
      if (st) ns++;
      guard++;
    end while (st && guard < 20);
    if (guard >= 20) check("op_timeout", 32'(guard), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_stall[%0d]", d), 32'(st_o[d]), 32'd0);
      check_regs(d);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int ns;
    bit st;
    rst_n = 1'b1;
    model_reset();
    set_in(2'b00, 5'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
    #2;
    apply_reset();

    // Preload words 0..15 so every later read hits known data.
    for (int unsigned w = 0; w < 16; w++) begin
      set_in(2'b00, 5'b00010, 5'd0, {22'd0, 4'd0, 4'(w), 2'b00}, $urandom, 32'd0, 1'b0, 32'd0, 26'd0);
      run_op(ns);
    end

    // Store then load at 0x10.
    set_in(2'b00, 5'b00010, 5'd0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    check("sw_stall_cycles", 32'(ns), 32'd2);
    set_in(2'b11, 5'b00001, 5'd9, 32'h10, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    check("lw_stall_cycles", 32'(ns), 32'd2);
    check("lw_data", rdat_o[0], 32'hDEADBEEF);
    check("lw_wb", 32'(wb_o[0]), 32'd3);
    check("lw_data_w0", rdat_o[1], 32'hDEADBEEF);

    // Address wrap-around.
    set_in(2'b00, 5'b00010, 5'd0, 32'h400, 32'h1234, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    set_in(2'b10, 5'b00001, 5'd3, 32'h000, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    check("wrap_read", rdat_o[0], 32'h1234);

    // Read+write together behaves as a write.
    set_in(2'b11, 5'b00011, 5'd4, 32'h30, 32'hCAFE, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    check("rw_readdata_zero", rdat_o[0], 32'd0);

    // Branch taken / not taken, jump priority.
    set_in(2'b00, 5'b00100, 5'd0, 32'd0, 32'd0, 32'h40, 1'b1, 32'd0, 26'd0);
    #1;
    check("br_pcsrc", 32'(if2.PCSrc), 32'd1);
    check("br_target", if2.next_pc, 32'h40);
    step(st);
    set_in(2'b00, 5'b00100, 5'd0, 32'd0, 32'd0, 32'h40, 1'b0, 32'd0, 26'd0);
    #1;
    check("br_not_taken", 32'(if2.PCSrc), 32'd0);
    step(st);
    set_in(2'b00, 5'b01100, 5'd0, 32'd0, 32'd0, 32'h40, 1'b0, 32'h10000004, 26'h0000010);
    #1;
    check("jmp_pcsrc", 32'(if2.PCSrc), 32'd1);
    check("jmp_target", if2.next_pc, 32'h10000040);
    step(st);

    // Reset in the middle of a write's wait states.
    set_in(2'b00, 5'b00010, 5'd0, 32'h20, 32'h5, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    set_in(2'b00, 5'b00010, 5'd0, 32'h20, 32'h99, 32'd0, 1'b0, 32'd0, 26'd0);
    step(st);
    #3;
    apply_reset();
    set_in(2'b10, 5'b00001, 5'd7, 32'h20, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
    run_op(ns);
    check("rst_abort_read", rdat_o[0], 32'h5);

    // Randomized traffic over the preloaded window.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom;
      set_in(2'($urandom), 5'($urandom), 5'($urandom),
             {r[31:10], 4'd0, 4'($urandom), 2'($urandom)}, $urandom, $urandom,
             1'($urandom), $urandom, 26'($urandom));
      run_op(ns);
    end

    check("w0_never_stalls", 32'(stall0_seen), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
